// File: rtl/weight_fetch.sv
// Sequential weight reader: walks weight_bram from a base address, absorbs the
// one-cycle read latency, and hands out KSIZE-weight kernels over valid/ready.
module weight_fetch #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 8,
    parameter int KSIZE  = 9
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        base_addr,
    input  logic [7:0]               num_kernels,
    output logic [ADDR_W-1:0]        bram_addr,
    input  logic [DATA_W-1:0]        bram_data,
    output logic [DATA_W*KSIZE-1:0]  kernel_out,
    output logic                     kernel_valid,
    input  logic                     kernel_ready,
    output logic                     busy,
    output logic                     done
);

    localparam int CNT_W = $clog2(KSIZE + 1);

    typedef enum logic [1:0] {IDLE, FETCH, OUT} state_t;

    state_t            state, state_nxt;
    logic [7:0]        remaining;
    logic [CNT_W-1:0]  iss_cnt;     // addresses presented so far, including the current one
    logic [KSIZE-1:0]  slot_pipe;   // bit j: bram_data this cycle belongs to slot j
    logic              zero_pend;

    logic ld_run, zero_run, issue, cap_done, hs, hs_last, hs_more;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && num_kernels != 8'd0) state_nxt = FETCH;
            FETCH:   if (slot_pipe[KSIZE-1]) state_nxt = OUT;
            OUT:     if (kernel_valid && kernel_ready)
                         state_nxt = (remaining == 8'd1) ? IDLE : FETCH;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ld_run   = 1'b0;
        zero_run = 1'b0;
        issue    = 1'b0;
        cap_done = 1'b0;
        hs       = 1'b0;
        case (state)
            IDLE: begin
                ld_run   = start && (num_kernels != 8'd0);
                zero_run = start && (num_kernels == 8'd0);
            end
            FETCH: begin
                issue    = iss_cnt < CNT_W'(KSIZE);
                cap_done = slot_pipe[KSIZE-1];
            end
            OUT:     hs = kernel_valid && kernel_ready;
            default: ;
        endcase
        hs_last = hs && (remaining == 8'd1);
        hs_more = hs && (remaining != 8'd1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bram_addr    <= '0;
            kernel_out   <= '0;
            kernel_valid <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            remaining    <= '0;
            iss_cnt      <= '0;
            slot_pipe    <= '0;
            zero_pend    <= 1'b0;
        end else begin
            // An empty run still reports completion, one edge after start is sampled.
            zero_pend <= zero_run;
            done      <= zero_pend | hs_last;

            if (ld_run) begin
                bram_addr <= base_addr;
                remaining <= num_kernels;
                iss_cnt   <= CNT_W'(1);
                busy      <= 1'b1;
            end

            if (state == FETCH) begin
                slot_pipe <= {slot_pipe[KSIZE-2:0], iss_cnt == CNT_W'(1)};
                for (int j = 0; j < KSIZE; j++)
                    if (slot_pipe[j]) kernel_out[DATA_W*j +: DATA_W] <= bram_data;
            end

            if (issue) begin
                bram_addr <= bram_addr + ADDR_W'(1);
                iss_cnt   <= iss_cnt + CNT_W'(1);
            end

            if (cap_done) kernel_valid <= 1'b1;

            if (hs) begin
                kernel_valid <= 1'b0;
                remaining    <= remaining - 8'd1;
            end

            if (hs_last) busy <= 1'b0;

            // Next kernel starts right after the last address of this one.
            if (hs_more) begin
                bram_addr <= bram_addr + ADDR_W'(1);
                iss_cnt   <= CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_weight_fetch.sv
// Directed bench for weight_fetch with a 1-cycle-latency BRAM model
// holding mem[i] = (i*17+3) & 0xFF.
module tb_weight_fetch;

    localparam int ADDR_W = 15;
    localparam int DATA_W = 8;
    localparam int KSIZE  = 9;

    localparam logic [71:0] K0 = 72'h8B7A69584736251403;
    localparam logic [71:0] K1 = 72'h241302F1E0CFBEAD9C;
    localparam logic [71:0] KW = 72'h4736251403F2E1D0BF;

    logic                     clk;
    logic                     reset;
    logic                     start;
    logic [ADDR_W-1:0]        base_addr;
    logic [7:0]               num_kernels;
    logic [ADDR_W-1:0]        bram_addr;
    logic [DATA_W-1:0]        bram_data;
    logic [DATA_W*KSIZE-1:0]  kernel_out;
    logic                     kernel_valid;
    logic                     kernel_ready;
    logic                     busy;
    logic                     done;

    logic [7:0]        mem [0:32767];
    logic [ADDR_W-1:0] addr_log [0:15];
    logic [ADDR_W-1:0] max_addr;
    logic [ADDR_W-1:0] wexp [0:8] = '{15'h7FFC, 15'h7FFD, 15'h7FFE, 15'h7FFF,
                                      15'h0000, 15'h0001, 15'h0002, 15'h0003, 15'h0004};
    int vecs = 0;
    int errs = 0;

    weight_fetch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .KSIZE(KSIZE)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .num_kernels(num_kernels), .bram_addr(bram_addr), .bram_data(bram_data),
        .kernel_out(kernel_out), .kernel_valid(kernel_valid),
        .kernel_ready(kernel_ready), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) bram_data <= mem[bram_addr];

    task automatic tick();
        @(posedge clk);
        #1;
        if (bram_addr > max_addr) max_addr = bram_addr;
    endtask

    // Leaves the bench in cycle 1 (just after the edge that samples start).
    task automatic do_start(input logic [ADDR_W-1:0] b, input logic [7:0] n);
        base_addr   = b;
        num_kernels = n;
        start       = 1'b1;
        tick();
        start       = 1'b0;
    endtask

    // Returns the cycle index in which kernel_valid is first seen (bounded).
    task automatic wait_valid(input int n0, output int n);
        n = n0;
        if (n < 16) addr_log[n] = bram_addr;
        while (kernel_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
            if (n < 16) addr_log[n] = bram_addr;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        vecs++; if (bram_addr !== '0)    begin errs++; $display("FAIL reset_addr got %h want 0", bram_addr); end
        vecs++; if (kernel_out !== '0)   begin errs++; $display("FAIL reset_kernel got %h want 0", kernel_out); end
        vecs++; if (kernel_valid !== 0)  begin errs++; $display("FAIL reset_valid got %b want 0", kernel_valid); end
        vecs++; if (busy !== 0)          begin errs++; $display("FAIL reset_busy got %b want 0", busy); end
        vecs++; if (done !== 0)          begin errs++; $display("FAIL reset_done got %b want 0", done); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single();
        int n;
        kernel_ready = 1'b1;
        do_start(15'h0000, 8'd1);
        vecs++; if (busy !== 1) begin errs++; $display("FAIL single_busy got %b want 1", busy); end
        wait_valid(1, n);
        vecs++; if (n != 11)             begin errs++; $display("FAIL single_latency got cycle %0d want 11", n); end
        vecs++; if (addr_log[1] !== 15'd0) begin errs++; $display("FAIL single_addr1 got %h want 0", addr_log[1]); end
        vecs++; if (addr_log[9] !== 15'd8) begin errs++; $display("FAIL single_addr9 got %h want 8", addr_log[9]); end
        vecs++; if (kernel_out !== K0)   begin errs++; $display("FAIL single_kernel got %h want %h", kernel_out, K0); end
        tick();
        vecs++; if (kernel_valid !== 0)  begin errs++; $display("FAIL single_valid_width got %b want 0", kernel_valid); end
        vecs++; if (done !== 1)          begin errs++; $display("FAIL single_done got %b want 1", done); end
        vecs++; if (busy !== 0)          begin errs++; $display("FAIL single_busy_end got %b want 0", busy); end
        tick();
        vecs++; if (done !== 0)          begin errs++; $display("FAIL single_done_pulse got %b want 0", done); end
    endtask

    task automatic test_backpressure();
        int  n;
        logic held;
        kernel_ready = 1'b0;
        max_addr     = '0;
        do_start(15'h0000, 8'd2);
        wait_valid(1, n);
        vecs++; if (kernel_out !== K0) begin errs++; $display("FAIL bp_kernel0 got %h want %h", kernel_out, K0); end
        held = 1'b1;
        repeat (5) begin
            tick();
            if (kernel_valid !== 1'b1 || kernel_out !== K0) held = 1'b0;
        end
        vecs++; if (held !== 1'b1) begin errs++; $display("FAIL bp_hold got valid=%b kernel=%h want 1/%h", kernel_valid, kernel_out, K0); end
        kernel_ready = 1'b1;
        tick();
        vecs++; if (kernel_valid !== 0) begin errs++; $display("FAIL bp_accept got %b want 0", kernel_valid); end
        wait_valid(1, n);
        vecs++; if (kernel_out !== K1) begin errs++; $display("FAIL bp_kernel1 got %h want %h", kernel_out, K1); end
        tick();
        vecs++; if (done !== 1)        begin errs++; $display("FAIL bp_done got %b want 1", done); end
        vecs++; if (max_addr !== 15'd17) begin errs++; $display("FAIL bp_max_addr got %0d want 17", max_addr); end
    endtask

    task automatic test_back_to_back();
        int n;
        kernel_ready = 1'b1;
        do_start(15'h0000, 8'd2);
        wait_valid(1, n);
        vecs++; if (kernel_out !== K0) begin errs++; $display("FAIL b2b_kernel0 got %h want %h", kernel_out, K0); end
        tick();
        vecs++; if (kernel_valid !== 0 || busy !== 1 || done !== 0)
            begin errs++; $display("FAIL b2b_mid got v=%b b=%b d=%b want 0/1/0", kernel_valid, busy, done); end
        wait_valid(1, n);
        vecs++; if (n != 11)           begin errs++; $display("FAIL b2b_period got cycle %0d want 11", n); end
        vecs++; if (kernel_out !== K1) begin errs++; $display("FAIL b2b_kernel1 got %h want %h", kernel_out, K1); end
        tick();
        vecs++; if (done !== 1 || busy !== 0) begin errs++; $display("FAIL b2b_end got d=%b b=%b want 1/0", done, busy); end
    endtask

    task automatic test_wrap();
        int n;
        kernel_ready = 1'b1;
        do_start(15'h7FFC, 8'd1);
        wait_valid(1, n);
        for (int i = 1; i <= 9; i++) begin
            vecs++;
            if (addr_log[i] !== wexp[i-1]) begin
                errs++; $display("FAIL wrap_addr[%0d] got %h want %h", i, addr_log[i], wexp[i-1]);
            end
        end
        vecs++; if (kernel_out !== KW) begin errs++; $display("FAIL wrap_kernel got %h want %h", kernel_out, KW); end
        tick();
        vecs++; if (done !== 1) begin errs++; $display("FAIL wrap_done got %b want 1", done); end
    endtask

    task automatic test_zero();
        do_start(15'h1234, 8'd0);
        vecs++; if (busy !== 0 || bram_addr !== 15'h0004)
            begin errs++; $display("FAIL zero_c1 got b=%b addr=%h want 0/0004", busy, bram_addr); end
        tick();
        vecs++; if (done !== 1)         begin errs++; $display("FAIL zero_done got %b want 1", done); end
        vecs++; if (busy !== 0 || kernel_valid !== 0)
            begin errs++; $display("FAIL zero_idle got b=%b v=%b want 0/0", busy, kernel_valid); end
        tick();
        vecs++; if (done !== 0 || bram_addr !== 15'h0004)
            begin errs++; $display("FAIL zero_after got d=%b addr=%h want 0/0004", done, bram_addr); end
    endtask

    task automatic test_start_busy();
        int n;
        kernel_ready = 1'b1;
        do_start(15'h0000, 8'd1);
        tick();
        tick();
        base_addr   = 15'h0100;
        num_kernels = 8'd3;
        start       = 1'b1;
        tick();
        start       = 1'b0;
        wait_valid(4, n);
        vecs++; if (n != 11)           begin errs++; $display("FAIL sb_latency got cycle %0d want 11", n); end
        vecs++; if (kernel_out !== K0) begin errs++; $display("FAIL sb_kernel got %h want %h", kernel_out, K0); end
        tick();
        vecs++; if (done !== 1)        begin errs++; $display("FAIL sb_done got %b want 1", done); end
        tick();
        vecs++; if (busy !== 0 || bram_addr !== 15'd8)
            begin errs++; $display("FAIL sb_idle got b=%b addr=%h want 0/0008", busy, bram_addr); end
    endtask

    task automatic test_reset_mid();
        int n;
        kernel_ready = 1'b1;
        do_start(15'h0000, 8'd2);
        repeat (3) tick();
        reset = 1'b1;
        #1;
        vecs++; if (bram_addr !== '0 || kernel_out !== '0 || kernel_valid !== 0 || busy !== 0 || done !== 0)
            begin errs++; $display("FAIL rst_mid got addr=%h k=%h v=%b b=%b d=%b want all 0",
                                   bram_addr, kernel_out, kernel_valid, busy, done); end
        tick();
        vecs++; if (done !== 0 || busy !== 0) begin errs++; $display("FAIL rst_hold got d=%b b=%b want 0/0", done, busy); end
        reset = 1'b0;
        tick();
        do_start(15'd9, 8'd1);
        wait_valid(1, n);
        vecs++; if (n != 11)           begin errs++; $display("FAIL rst_restart_lat got cycle %0d want 11", n); end
        vecs++; if (kernel_out !== K1) begin errs++; $display("FAIL rst_restart_kernel got %h want %h", kernel_out, K1); end
        tick();
        vecs++; if (done !== 1)        begin errs++; $display("FAIL rst_restart_done got %b want 1", done); end
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) mem[i] = 8'((i * 17 + 3) & 255);
        reset        = 1'b1;
        start        = 1'b0;
        base_addr    = '0;
        num_kernels  = '0;
        kernel_ready = 1'b0;
        max_addr     = '0;
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_wrap();
        test_zero();
        test_start_busy();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/weight_fetch.md
# weight_fetch

Sequential reader for `weight_bram`. It walks a contiguous run of 8-bit weights starting at a base address and absorbs the BRAM's one-cycle read latency. Each group of KSIZE consecutive weights is packed into one kernel word and handed to the convolution engine over a valid/ready handshake. It sits between the weight store and the MAC array, opposite the loader that fills the BRAM.

## Interface
Parameters:
- ADDR_W, 15, BRAM address width
- DATA_W, 8, weight width
- KSIZE, 9, weights per kernel (3x3)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request to begin a fetch run
- base_addr  in  ADDR_W  address of the first weight, sampled with start
- num_kernels  in  8  number of kernels to fetch, sampled with start
- bram_addr  out  ADDR_W  read address to weight_bram
- bram_data  in  DATA_W  weight_bram data_out
- kernel_out  out  DATA_W*KSIZE  packed kernel; weight j at bits [DATA_W*j +: DATA_W], j=0 is the lowest address
- kernel_valid  out  1  kernel_out holds a complete kernel
- kernel_ready  in  1  consumer accepts the kernel
- busy  out  1  run in progress
- done  out  1  one-cycle pulse when the run completes

## Operation
- FSM states: IDLE, FETCH, OUT.
- IDLE:
  - start=1 latches base_addr into ptr and num_kernels into the remaining count.
  - If num_kernels=0: done pulses next cycle, no reads are issued, FSM stays IDLE.
  - Otherwise: go to FETCH, bram_addr<=base_addr, busy<=1.
- start while busy is ignored.
- FETCH:
  - bram_addr advances by 1 each cycle for KSIZE addresses.
  - A one-bit-per-slot valid pipe tracks in-flight reads.
  - The byte for the address presented in cycle c arrives on bram_data in cycle c+1 and is captured into slot j at the end of c+1.
  - After slot KSIZE-1 is captured: kernel_valid<=1, go to OUT.
- OUT:
  - kernel_out and kernel_valid are held stable while kernel_ready=0.
  - At the edge with kernel_valid&kernel_ready, the remaining count decrements.
  - If the count was 1: kernel_valid<=0, busy<=0, done<=1 for one cycle, go to IDLE.
  - Else: kernel_valid<=0, bram_addr<=next address, go to FETCH.
- No prefetch of the next kernel while OUT is held.
- Address arithmetic is modulo 2^ADDR_W; base+k wraps past the all-ones address to 0.
- bram_addr holds its last value in IDLE.

## Timing
- Reset values: bram_addr=0, kernel_out=0, kernel_valid=0, busy=0, done=0, FSM=IDLE, slot pipe cleared.
- Reset asserted mid-run aborts immediately. No done pulse; the next start is accepted normally.
- Let edge 0 be the edge that samples start:
  - bram_addr=base in cycle 1 and base+8 in cycle 9.
  - kernel_valid high from edge 10.
- With kernel_ready held high, kernel_valid is high for exactly 1 cycle per kernel. Throughput is one kernel per KSIZE+2 cycles.
- After the last accepting edge: busy low and done high at that edge; done low one edge later.
- busy rises at edge 0 and stays high through the last handshake.
- kernel_out changes only at slot-capture edges.

## Test plan
- Setup: BRAM model with 1-cycle read latency, mem[i]=(i*17+3)&0xFF.
- Single kernel: base=0, num=1, ready=1.
  - kernel_out=0x8B7A69584736251403.
  - kernel_valid rises at edge 10 for 1 cycle.
  - done pulses once; busy low afterwards.
- Two kernels with backpressure: base=0, num=2, ready low for 5 cycles on the first kernel.
  - First kernel is held stable, unchanged.
  - Second kernel_out=0x241302F1E0CFBEAD9C.
  - bram_addr never exceeds 17.
- Wrap-around: base=0x7FFC, num=1.
  - bram_addr sequence is 7FFC, 7FFD, 7FFE, 7FFF, 0000, 0001, 0002, 0003, 0004.
  - kernel packs those bytes in that order.
- Zero count: num=0.
  - done pulses at edge 1.
  - busy stays 0; bram_addr is unchanged; kernel_valid stays 0.
- Start while busy: a second start with a different base mid-FETCH is ignored; the first run completes with correct data.
- Reset mid-run: assert reset during FETCH.
  - All outputs are 0 immediately, with no done pulse.
  - A new start with base=9, num=1 then yields 0x241302F1E0CFBEAD9C.
